// File: rtl/snail_pkg.sv
// Shared types and defaults for the snail serial transmitter.
package snail_pkg;

  localparam int unsigned SNAIL_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/snail_rise_cnt.sv
// Saturating count of 0->1 transitions between the current and next serial bit.
module snail_rise_cnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             _rst,
  input  logic             clr,
  input  logic             d_old,
  input  logic             d_new,
  output logic [CNT_W-1:0] count
);

  logic rise_c;

  assign rise_c = d_new & ~d_old;

  // A clear still counts a rise on the first bit of the new frame.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      count <= '0;
    end else if (clr) begin
      count <= CNT_W'(rise_c);
    end else if (rise_c && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/snail_tx.sv
// Loads a parallel word and shifts it out MSB-first on D, counting emitted rising edges.
module snail_tx
  import snail_pkg::*;
#(
  parameter int unsigned WIDTH = SNAIL_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             _rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [CNT_W-1:0] len,
  output logic             D,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] rise_cnt
);

  tx_state_t        state, state_nxt;
  logic [WIDTH-1:0] sr, sr_nxt;
  logic [CNT_W-1:0] rem, rem_nxt;
  logic             d_nxt, busy_nxt, done_nxt, err_nxt;
  logic             clr_c, legal_c;
  logic [WIDTH-1:0] aligned_c;

  assign legal_c   = (len != '0) && (len <= CNT_W'(WIDTH));
  // Left-justify the active field so the frame MSB sits at the register top.
  assign aligned_c = data << (CNT_W'(WIDTH) - len);

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state <= IDLE;
      sr    <= '0;
      rem   <= '0;
      D     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      sr    <= sr_nxt;
      rem   <= rem_nxt;
      D     <= d_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    rem_nxt   = rem;
    d_nxt     = D;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    clr_c     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (legal_c) begin
            state_nxt = SHIFT;
            d_nxt     = aligned_c[WIDTH-1];
            sr_nxt    = aligned_c << 1;
            rem_nxt   = len - CNT_W'(1);
            clr_c     = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      // rem counts bits still to emit after the one already on D.
      SHIFT: begin
        if (rem == '0) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else begin
          d_nxt   = sr[WIDTH-1];
          sr_nxt  = sr << 1;
          rem_nxt = rem - CNT_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  snail_rise_cnt #(.CNT_W(CNT_W)) u_rise_cnt (
    .clk   (clk),
    ._rst  (_rst),
    .clr   (clr_c),
    .d_old (D),
    .d_new (d_nxt),
    .count (rise_cnt)
  );

endmodule

// File: tb/tb_snail_tx.sv
// Directed bench for snail_tx: frame timing, rise counting, illegal length, busy-start and reset abort.
module tb_snail_tx;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          _rst;
  logic          start;
  logic [W-1:0]  data;
  logic [CW-1:0] len;
  logic          D, busy, done, err;
  logic [CW-1:0] rise_cnt;

  int total = 0;
  int bad   = 0;

  snail_tx #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk      (clk),
    ._rst     (_rst),
    .start    (start),
    .data     (data),
    .len      (len),
    .D        (D),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .rise_cnt (rise_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one frame; bits is the expected D sequence, noise pulses start in SHIFT and DONE.
  task automatic send(input string tag, input logic [W-1:0] d, input logic [CW-1:0] l,
                      input string bits, input int rise, input bit noise);
    data  = d;
    len   = l;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < int'(l); i++) begin
      check($sformatf("%s_d%0d", tag, i), 32'(D), 32'(bits[i] == "1"));
      check($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'd1);
      check($sformatf("%s_done%0d", tag, i), 32'(done), 32'd0);
      if (i < int'(l) - 1) begin
        if (noise && i == 0) begin
          start = 1'b1;
          data  = 8'h00;
          len   = 4'd3;
        end
        tick();
        start = 1'b0;
      end
    end
    tick();
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_done"}, 32'(busy), 32'd1);
    check({tag, "_d_hold"}, 32'(D), 32'(bits[int'(l) - 1] == "1"));
    if (noise) start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_done_end"}, 32'(done), 32'd0);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_err_end"}, 32'(err), 32'd0);
    check({tag, "_rise"}, 32'(rise_cnt), 32'(rise));
    if (noise) begin
      tick();
      check({tag, "_idle_after"}, 32'(busy), 32'd0);
      check({tag, "_d_idle"}, 32'(D), 32'(bits[int'(l) - 1] == "1"));
    end
  endtask

  task automatic bad_len(input string tag, input logic [CW-1:0] l, input logic d_exp,
                         input int rise_exp);
    len   = l;
    data  = 8'hA5;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_err"}, 32'(err), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_d"}, 32'(D), 32'(d_exp));
    check({tag, "_rise"}, 32'(rise_cnt), 32'(rise_exp));
    tick();
    check({tag, "_err_clr"}, 32'(err), 32'd0);
    check({tag, "_busy2"}, 32'(busy), 32'd0);
  endtask

  initial begin
    _rst  = 1'b0;
    start = 1'b0;
    data  = '0;
    len   = '0;
    #2;
    check("rst_d", 32'(D), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rise", 32'(rise_cnt), 32'd0);
    tick();
    tick();
    _rst = 1'b1;
    tick();

    send("t2", 8'b1011_0010, 4'd8, "10110010", 3, 1'b0);

    send("t3a", 8'b0000_0101, 4'd3, "101", 2, 1'b0);
    send("t3b", 8'hFF, 4'd8, "11111111", 0, 1'b0);

    bad_len("t4a", 4'd0, 1'b1, 0);
    bad_len("t4b", 4'd9, 1'b1, 0);

    send("t5a", 8'h09, 4'd4, "1001", 1, 1'b1);
    send("t5b", 8'h01, 4'd2, "01", 1, 1'b0);

    // Abort a frame of 0,1,1,1,... after its fourth bit
    data  = 8'h70;
    len   = 4'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("t6_pre_d", 32'(D), 32'd1);
    check("t6_pre_rise", 32'(rise_cnt), 32'd1);
    check("t6_pre_busy", 32'(busy), 32'd1);
    _rst = 1'b0;
    #1;
    check("t6_rst_d", 32'(D), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    check("t6_rst_err", 32'(err), 32'd0);
    check("t6_rst_rise", 32'(rise_cnt), 32'd0);
    tick();
    _rst = 1'b1;
    tick();
    send("t6", 8'h01, 4'd8, "00000001", 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
